// File: rtl/csr_row_scatter.sv
// Sparse (column, value) row stream to dense ROW_W-bit row scatter with valid/ready on both sides.
// Optional duplicate-column detection is compiled in with `define CSR_DUP_CHECK_EN.
module csr_row_scatter #(
    parameter int ELEM_W = 32,
    parameter int N_ELEM = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          elem_valid_i,
    output logic                          elem_ready_o,
    input  logic [$clog2(N_ELEM)-1:0]     elem_col_i,
    input  logic [ELEM_W-1:0]             elem_val_i,
    input  logic                          elem_last_i,
    input  logic                          elem_null_i,
    output logic                          row_valid_o,
    input  logic                          row_ready_i,
    output logic [ELEM_W*N_ELEM-1:0]      row_data_o,
    output logic [$clog2(N_ELEM):0]       row_nnz_o,
    output logic                          dup_err_o
);

    localparam int COL_W = $clog2(N_ELEM);
    localparam int ROW_W = ELEM_W * N_ELEM;
    localparam logic [COL_W:0] NNZ_MAX = (COL_W + 1)'(N_ELEM);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ROW_W-1:0] rowBuf_q, rowBuf_d;
    logic [COL_W:0]   nnz_q, nnz_d;
    logic             writeEn;
    logic             rowDone;

    assign writeEn = (state_q == S_FILL) && elem_valid_i && !elem_null_i;
    assign rowDone = (state_q == S_HOLD) && row_ready_i;

    // Column 0 lands in the most significant word, column N_ELEM-1 in the least.
    always_comb begin
        state_d  = state_q;
        rowBuf_d = rowBuf_q;
        nnz_d    = nnz_q;
        case (state_q)
            S_FILL: begin
                if (writeEn) begin
                    for (int i = 0; i < N_ELEM; i++) begin
                        if (elem_col_i == COL_W'(i)) begin
                            rowBuf_d[ROW_W-ELEM_W*(i+1) +: ELEM_W] = elem_val_i;
                        end
                    end
                    if (nnz_q != NNZ_MAX) begin
                        nnz_d = nnz_q + 1'b1;
                    end
                end
                if (elem_valid_i && elem_last_i) begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                if (rowDone) begin
                    rowBuf_d = '0;
                    nnz_d    = '0;
                    state_d  = S_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_FILL;
            rowBuf_q <= '0;
            nnz_q    <= '0;
        end else begin
            state_q  <= state_d;
            rowBuf_q <= rowBuf_d;
            nnz_q    <= nnz_d;
        end
    end

    assign elem_ready_o = (state_q == S_FILL);
    assign row_valid_o  = (state_q == S_HOLD);
    assign row_data_o   = rowBuf_q;
    assign row_nnz_o    = nnz_q;

`ifdef CSR_DUP_CHECK_EN
    logic [N_ELEM-1:0] colMask_q, colMask_d;
    logic              dupErr_q, dupErr_d;

    // The mask lives and dies with the row buffer; the error flag only clears on reset.
    always_comb begin
        colMask_d = colMask_q;
        dupErr_d  = dupErr_q;
        if (rowDone) begin
            colMask_d = '0;
        end else if (writeEn) begin
            if (colMask_q[elem_col_i]) begin
                dupErr_d = 1'b1;
            end
            colMask_d[elem_col_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            colMask_q <= '0;
            dupErr_q  <= 1'b0;
        end else begin
            colMask_q <= colMask_d;
            dupErr_q  <= dupErr_d;
        end
    end

    assign dup_err_o = dupErr_q;
`else
    assign dup_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_csr_row_scatter.sv
// Self-checking bench for csr_row_scatter: directed plan plus randomized rows against an array-based row model.
// Build with +define+CSR_DUP_CHECK_EN to exercise the duplicate-column flag.
module tb_csr_row_scatter;

    localparam int ELEM_W = 32;
    localparam int N_ELEM = 16;
    localparam int ROW_W  = ELEM_W * N_ELEM;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              elem_valid_i = 1'b0;
    logic              elem_ready_o;
    logic [3:0]        elem_col_i = '0;
    logic [31:0]       elem_val_i = '0;
    logic              elem_last_i = 1'b0;
    logic              elem_null_i = 1'b0;
    logic              row_valid_o;
    logic              row_ready_i = 1'b0;
    logic [ROW_W-1:0]  row_data_o;
    logic [4:0]        row_nnz_o;
    logic              dup_err_o;

    int nChecks = 0;
    int nPass   = 0;
    int readyMode = 1;
    bit chkEn = 1'b0;

    // Model: one word per column, plus counters and flags describing the row.
    logic [31:0] mRow [N_ELEM];
    int          mNnz;
    bit          mHold;
    bit          mMask [N_ELEM];
    bit          mDup;

    csr_row_scatter #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .elem_valid_i (elem_valid_i),
        .elem_ready_o (elem_ready_o),
        .elem_col_i   (elem_col_i),
        .elem_val_i   (elem_val_i),
        .elem_last_i  (elem_last_i),
        .elem_null_i  (elem_null_i),
        .row_valid_o  (row_valid_o),
        .row_ready_i  (row_ready_i),
        .row_data_o   (row_data_o),
        .row_nnz_o    (row_nnz_o),
        .dup_err_o    (dup_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [ROW_W-1:0] packRow();
        logic [ROW_W-1:0] r = '0;
        for (int c = 0; c < N_ELEM; c++) r[ROW_W-1-32*c -: 32] = mRow[c];
        return r;
    endfunction

    function automatic logic [31:0] wordOf(input logic [ROW_W-1:0] r, input int c);
        return r[ROW_W-1-32*c -: 32];
    endfunction

    task automatic checkOutput(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic clearModelRow();
        for (int c = 0; c < N_ELEM; c++) begin
            mRow[c]  = '0;
            mMask[c] = 1'b0;
        end
        mNnz  = 0;
        mHold = 1'b0;
    endtask

    // Reference behaviour, sampled at the accepting edge.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clearModelRow();
            mDup = 1'b0;
        end else if (!mHold) begin
            if (elem_valid_i) begin
                if (!elem_null_i) begin
                    if (mMask[elem_col_i]) mDup = 1'b1;
                    mMask[elem_col_i] = 1'b1;
                    mRow[elem_col_i]  = elem_val_i;
                    if (mNnz < N_ELEM) mNnz++;
                end
                if (elem_last_i) mHold = 1'b1;
            end
        end else if (row_ready_i) begin
            clearModelRow();
        end
    end

    always @(negedge clk_i) begin
        if (readyMode == 0) row_ready_i = 1'($urandom_range(0, 1));
        else row_ready_i = (readyMode == 1);
    end

    always @(negedge clk_i) begin
        if (!rst_i && chkEn) begin
            checkOutput("elem_ready", ROW_W'(elem_ready_o), ROW_W'(!mHold));
            checkOutput("row_valid", ROW_W'(row_valid_o), ROW_W'(mHold));
            if (mHold) begin
                checkOutput("row_data", row_data_o, packRow());
                checkOutput("row_nnz", ROW_W'(row_nnz_o), ROW_W'(mNnz));
            end
`ifdef CSR_DUP_CHECK_EN
            checkOutput("dup_err", ROW_W'(dup_err_o), ROW_W'(mDup));
`else
            checkOutput("dup_err", ROW_W'(dup_err_o), '0);
`endif
        end
    end

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic applyStimulus(input int col, input logic [31:0] val, input bit last, input bit isNull);
        int waitCycles = 0;
        elem_valid_i = 1'b1;
        elem_col_i   = 4'(col);
        elem_val_i   = val;
        elem_last_i  = last;
        elem_null_i  = isNull;
        while (!elem_ready_o && waitCycles < 500) begin
            @(negedge clk_i);
            waitCycles++;
        end
        if (waitCycles >= 500) begin
            nChecks++;
            $display("[TB] FAIL accept_timeout: col %0d still waiting after %0d cycles, required acceptance", col, waitCycles);
        end else begin
            @(negedge clk_i);
        end
        elem_valid_i = 1'b0;
        elem_last_i  = 1'b0;
        elem_null_i  = 1'b0;
    endtask

    task automatic waitRowTaken();
        int n = 0;
        while (row_valid_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 500) begin
            nChecks++;
            $display("[TB] FAIL row_drain_timeout: row_valid still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, ROW_W'(row_valid_o), '0);
        checkOutput({tag, "_data"}, row_data_o, '0);
        checkOutput({tag, "_nnz"}, ROW_W'(row_nnz_o), '0);
        checkOutput({tag, "_ready"}, ROW_W'(elem_ready_o), ROW_W'(1));
        checkOutput({tag, "_dup"}, ROW_W'(dup_err_o), '0);
    endtask

    initial begin
        #1000000;
        nChecks++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        logic [ROW_W-1:0] snap;
        logic [31:0] rv;

        repeat (2) @(negedge clk_i);
        checkResetState("reset_init");
        rst_i = 1'b0;
        chkEn = 1'b1;
        @(negedge clk_i);

        $display("[TB] dense row");
        readyMode = 2;
        for (int c = 0; c < N_ELEM; c++) applyStimulus(c, 32'h100 + 32'(c), c == N_ELEM - 1, 1'b0);
        checkOutput("dense_valid", ROW_W'(row_valid_o), ROW_W'(1));
        checkOutput("dense_msw", ROW_W'(row_data_o[511:480]), ROW_W'(32'h100));
        checkOutput("dense_lsw", ROW_W'(row_data_o[31:0]), ROW_W'(32'h10F));
        checkOutput("dense_nnz", ROW_W'(row_nnz_o), ROW_W'(16));
        readyMode = 1;
        waitRowTaken();

        $display("[TB] sparse out-of-order row");
        readyMode = 2;
        applyStimulus(9, 32'hAAAA0009, 1'b0, 1'b0);
        applyStimulus(3, 32'hAAAA0003, 1'b0, 1'b0);
        applyStimulus(15, 32'hAAAA000F, 1'b1, 1'b0);
        checkOutput("sparse_w3", ROW_W'(row_data_o[415:384]), ROW_W'(32'hAAAA0003));
        checkOutput("sparse_w9", ROW_W'(row_data_o[223:192]), ROW_W'(32'hAAAA0009));
        checkOutput("sparse_w15", ROW_W'(row_data_o[31:0]), ROW_W'(32'hAAAA000F));
        checkOutput("sparse_w0", ROW_W'(row_data_o[511:480]), '0);
        checkOutput("sparse_nnz", ROW_W'(row_nnz_o), ROW_W'(3));
        readyMode = 1;
        waitRowTaken();

        $display("[TB] empty row with backpressure");
        readyMode = 2;
        applyStimulus(0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        checkOutput("empty_data", row_data_o, '0);
        checkOutput("empty_nnz", ROW_W'(row_nnz_o), '0);
        snap = row_data_o;
        elem_valid_i = 1'b1;
        elem_col_i   = 4'd2;
        elem_val_i   = 32'h2222_0002;
        elem_last_i  = 1'b1;
        elem_null_i  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checkOutput("bp_ready", ROW_W'(elem_ready_o), '0);
            checkOutput("bp_stable", row_data_o, snap);
        end
        readyMode = 1;
        applyStimulus(2, 32'h2222_0002, 1'b1, 1'b0);
        readyMode = 2;
        @(negedge clk_i);
        checkOutput("bp_next_valid", ROW_W'(row_valid_o), ROW_W'(1));
        checkOutput("bp_next_w2", ROW_W'(row_data_o[447:416]), ROW_W'(32'h2222_0002));
        checkOutput("bp_next_rest", row_data_o & ~({ROW_W{1'b0}} | (ROW_W'(32'hFFFF_FFFF) << 416)), '0);
        checkOutput("bp_next_nnz", ROW_W'(row_nnz_o), ROW_W'(1));
        readyMode = 1;
        waitRowTaken();

        $display("[TB] reset mid-row");
        applyStimulus(1, 32'h0000_0011, 1'b0, 1'b0);
        applyStimulus(4, 32'h0000_0044, 1'b0, 1'b0);
        rst_i = 1'b1;
        #2;
        checkResetState("reset_mid");
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        readyMode = 2;
        applyStimulus(7, 32'h7777_0007, 1'b1, 1'b0);
        checkOutput("rst_row_w7", ROW_W'(wordOf(row_data_o, 7)), ROW_W'(32'h7777_0007));
        checkOutput("rst_row_w1", ROW_W'(wordOf(row_data_o, 1)), '0);
        checkOutput("rst_row_w4", ROW_W'(wordOf(row_data_o, 4)), '0);
        checkOutput("rst_row_nnz", ROW_W'(row_nnz_o), ROW_W'(1));
        readyMode = 1;
        waitRowTaken();

        $display("[TB] nnz saturation");
        readyMode = 2;
        for (int k = 0; k < 20; k++) applyStimulus(k % N_ELEM, 32'h5000 + 32'(k), k == 19, 1'b0);
        checkOutput("sat_nnz", ROW_W'(row_nnz_o), ROW_W'(16));
        checkOutput("sat_w3", ROW_W'(wordOf(row_data_o, 3)), ROW_W'(32'h5013));
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] duplicate column");
        applyStimulus(5, 32'h11, 1'b0, 1'b0);
        applyStimulus(5, 32'h22, 1'b1, 1'b0);
        checkOutput("dup_w5", ROW_W'(wordOf(row_data_o, 5)), ROW_W'(32'h22));
        checkOutput("dup_nnz", ROW_W'(row_nnz_o), ROW_W'(2));
`ifdef CSR_DUP_CHECK_EN
        checkOutput("dup_flag", ROW_W'(dup_err_o), ROW_W'(1));
`else
        checkOutput("dup_flag", ROW_W'(dup_err_o), '0);
`endif
        readyMode = 1;
        waitRowTaken();
        applyStimulus(6, 32'h66, 1'b1, 1'b0);
`ifdef CSR_DUP_CHECK_EN
        checkOutput("dup_sticky", ROW_W'(dup_err_o), ROW_W'(1));
`else
        checkOutput("dup_sticky", ROW_W'(dup_err_o), '0);
`endif
        waitRowTaken();

        $display("[TB] randomized rows");
        readyMode = 0;
        for (int k = 0; k < 400; k++) begin
            rv = $urandom;
            applyStimulus(int'($urandom_range(0, N_ELEM - 1)), rv,
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
        end
        readyMode = 1;
        waitRowTaken();
        @(negedge clk_i);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
